// File: rtl/fwd_hazard_tracker.sv
// Forwarding and load-use hazard unit: tracks in-flight producer destinations downstream of EX
// and derives per-operand forward selects plus a stall. Optional counters under FWD_HAZARD_STATS_EN.
module fwd_hazard_tracker #(
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        adv,
  input  logic                        flush,
  input  logic                        ex_valid,
  input  logic                        ex_we,
  input  logic                        ex_is_load,
  input  logic [ADDR_W-1:0]           ex_rd,
  input  logic [NUM_SRC-1:0]          src_used,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]                 stall_cnt,
  output logic [31:0]                 fwd_cnt
`endif
);

  if (LOAD_LAT >= DEPTH) begin : g_bad_load_lat
    $error("fwd_hazard_tracker: LOAD_LAT (%0d) must be below DEPTH (%0d)", LOAD_LAT, DEPTH);
  end

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] rd;
    logic              ld;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_in;
  logic [NUM_SRC-1:0] stall_req;

  // A stalled or flushed EX instruction enters the tracker as a bubble.
  assign ent_in = '{v: ex_valid & ex_we & ~flush & ~stall, rd: ex_rd, ld: ex_is_load};

  // NOTE: state registers use non-blocking assignments so every entry samples its
  // neighbour's pre-edge value; blocking here would collapse the shift into one copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: only the valid bit needs clearing; rd/ld of an invalid entry are never observed.
      for (int i = 0; i < DEPTH; i++) ent_q[i].v <= 1'b0;
    end else if (adv) begin
      ent_q[0] <= ent_in;
      for (int i = 1; i < DEPTH; i++) ent_q[i] <= ent_q[i-1];
    end
  end

  // Youngest matching producer decides; an unready load blocks older ready copies.
  always_comb begin : p_match
    logic found;
    // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
    fwd_sel   = '0;
    stall_req = '0;
    found     = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && src_used[j] && ent_q[i].v &&
            (ent_q[i].rd == src_addr[j*ADDR_W +: ADDR_W]) &&
            (src_addr[j*ADDR_W +: ADDR_W] != '0)) begin
          found = 1'b1;
          if (ent_q[i].ld && (i < LOAD_LAT)) stall_req[j] = 1'b1;
          else fwd_sel[j*SEL_W +: SEL_W] = SEL_W'(i + 1);
        end
      end
    end
  end

  assign stall = |stall_req;

`ifdef FWD_HAZARD_STATS_EN
  localparam int CNT_W = $clog2(NUM_SRC + 1);

  logic [CNT_W-1:0] n_fwd;
  logic [32:0]      fwd_sum;

  always_comb begin
    n_fwd = '0;
    for (int j = 0; j < NUM_SRC; j++)
      if (fwd_sel[j*SEL_W +: SEL_W] != '0) n_fwd = n_fwd + CNT_W'(1);
  end

  assign fwd_sum = {1'b0, fwd_cnt} + 33'(n_fwd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (adv) begin
      if (stall) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      end else begin
        fwd_cnt <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
    end
  end
`endif

endmodule
